// File: rtl/bit_serial_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bit_serial_tx_pkg
// Description : Bundle word width and transmitter state encoding shared by
//               the bit-serial transmitter and the neuron.
// Revision    : 1.0 - initial release
// ============================================================================
package bit_serial_tx_pkg;

    localparam int c_BUNDLE_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd1,
        SHIFT   = 2'd2,
        RELEASE = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/bit_serial_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bit_serial_fifo
// Description : Synchronous FIFO with registered level; pointers wrap modulo
//               DEPTH (power of two).
// Revision    : 1.0 - initial release
// ============================================================================
module bit_serial_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RSTB,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int                 c_AW         = $clog2(DEPTH);
    localparam logic [c_AW:0]      c_FULL_LEVEL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_AW:0]    r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == c_FULL_LEVEL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: the level gates every read.
    always_ff @(posedge CLK) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/bit_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : bit_serial_tx
// Description : REQ/ACK/DATA bundle driver sending buffered words LSB-first.
//               Optional macro BIT_SERIAL_TX_STATUS_EN adds TX_COUNT and OVF.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_serial_tx
    import bit_serial_tx_pkg::*;
#(
    parameter int WIDTH = c_BUNDLE_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RSTB,
    input  logic                     LOAD_VALID,
    output logic                     LOAD_READY,
    input  logic [WIDTH-1:0]         LOAD_DATA,
    input  logic                     OUT_REQ,
    output logic                     OUT_ACK,
    output logic                     OUT_DATA,
    output logic                     BUSY,
    output logic [$clog2(DEPTH):0]   FIFO_LEVEL
`ifdef BIT_SERIAL_TX_STATUS_EN
    ,
    output logic [15:0]              TX_COUNT,
    output logic                     OVF
`endif
);

    localparam int                 c_CW       = $clog2(WIDTH);
    localparam logic [c_CW-1:0]    c_LAST_BIT = c_CW'(WIDTH - 2);

    tx_state_t        r_state;
    tx_state_t        w_state_nxt;
    logic             r_armed;
    logic             w_armed_nxt;
    logic             w_pop;
    logic             w_sending;
    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] w_head;
    logic [WIDTH-1:0] r_shreg;
    logic [c_CW-1:0]  r_bit_cnt;
    logic             r_out_ack;
    logic             r_out_data;
    logic             r_busy;

    bit_serial_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RSTB    (RSTB),
        .i_push  (LOAD_VALID),
        .i_wdata (LOAD_DATA),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (FIFO_LEVEL)
    );

    assign LOAD_READY = !w_full;
    assign w_sending  = (r_state == ACK) || (r_state == SHIFT);

    always_comb begin
        w_state_nxt = r_state;
        w_armed_nxt = r_armed;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (OUT_REQ && !w_empty && r_armed) begin
                    w_state_nxt = ACK;
                    w_pop       = 1'b1;
                    w_armed_nxt = 1'b0;
                end
            end
            ACK: begin
                w_state_nxt = SHIFT;
            end
            SHIFT: begin
                // An early REQ drop re-arms here so RELEASE lasts one cycle.
                if (!OUT_REQ) w_armed_nxt = 1'b1;
                if (r_bit_cnt == c_LAST_BIT) w_state_nxt = RELEASE;
            end
            RELEASE: begin
                if (!OUT_REQ || r_armed) begin
                    w_armed_nxt = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_state <= IDLE;
            r_armed <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_armed <= w_armed_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_shreg <= w_head;
            end else if (w_sending) begin
                r_shreg <= r_shreg >> 1;
            end
            if (r_state == ACK) begin
                r_bit_cnt <= '0;
            end else if (r_state == SHIFT) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    // Outputs trail the state by one register stage.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_out_ack  <= 1'b0;
            r_out_data <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_out_ack  <= (r_state == ACK);
            r_out_data <= w_sending && r_shreg[0];
            r_busy     <= w_sending;
        end
    end

    assign OUT_ACK  = r_out_ack;
    assign OUT_DATA = r_out_data;
    assign BUSY     = r_busy;

`ifdef BIT_SERIAL_TX_STATUS_EN
    logic [15:0] r_tx_count;
    logic        r_ovf;

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_tx_count <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (r_state == ACK)            r_tx_count <= r_tx_count + 16'd1;
            if (LOAD_VALID && !LOAD_READY) r_ovf      <= 1'b1;
        end
    end

    assign TX_COUNT = r_tx_count;
    assign OVF      = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_bit_serial_tx
// Description : Self-checking bench for bit_serial_tx against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serial_tx;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          RSTB;
    logic          LOAD_VALID;
    logic          LOAD_READY;
    logic [7:0]    LOAD_DATA;
    logic          OUT_REQ;
    logic          OUT_ACK;
    logic          OUT_DATA;
    logic          BUSY;
    logic [LW-1:0] FIFO_LEVEL;
`ifdef BIT_SERIAL_TX_STATUS_EN
    logic [15:0]   TX_COUNT;
    logic          OVF;
    int            acks_sent = 0;
`endif

    int         errors = 0;
    int         checks = 0;
    logic [7:0] model_q[$];

    always #5 CLK = ~CLK;

    bit_serial_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RSTB       (RSTB),
        .LOAD_VALID (LOAD_VALID),
        .LOAD_READY (LOAD_READY),
        .LOAD_DATA  (LOAD_DATA),
        .OUT_REQ    (OUT_REQ),
        .OUT_ACK    (OUT_ACK),
        .OUT_DATA   (OUT_DATA),
        .BUSY       (BUSY),
        .FIFO_LEVEL (FIFO_LEVEL)
`ifdef BIT_SERIAL_TX_STATUS_EN
        ,
        .TX_COUNT   (TX_COUNT),
        .OVF        (OVF)
`endif
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Offers one word for one edge; the model keeps it only if READY was high.
    task automatic push_word(input logic [7:0] w);
        logic was_ready;
        was_ready  = LOAD_READY;
        LOAD_DATA  = w;
        LOAD_VALID = 1'b1;
        tick();
        LOAD_VALID = 1'b0;
        LOAD_DATA  = 8'($urandom);
        if (was_ready) model_q.push_back(w);
    endtask

    task automatic wait_ack(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (OUT_ACK === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Called in the ACK cycle; returns the decoded word and the cycle after it.
    task automatic collect_word(output logic [7:0] w, output logic tail_data,
                                output logic tail_busy, output logic framing_bad);
        w           = '0;
        w[0]        = OUT_DATA;
        framing_bad = (BUSY !== 1'b1);
`ifdef BIT_SERIAL_TX_STATUS_EN
        acks_sent++;
`endif
        for (int i = 1; i < 8; i++) begin
            tick();
            w[i] = OUT_DATA;
            if (OUT_ACK !== 1'b0 || BUSY !== 1'b1) framing_bad = 1'b1;
        end
        tick();
        tail_data = OUT_DATA;
        tail_busy = BUSY;
    endtask

    task automatic check_word(input string name, input logic [7:0] got,
                              input logic tail_data, input logic tail_busy,
                              input logic framing_bad);
        logic [7:0] exp;
        exp = (model_q.size() > 0) ? model_q.pop_front() : 8'hxx;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s word: got %02h expected %02h", name, got, exp);
        end
        checks++;
        if (tail_data !== 1'b0 || tail_busy !== 1'b0 || framing_bad !== 1'b0) begin
            errors++;
            $display("FAIL %s framing: tail_data=%b tail_busy=%b framing_bad=%b expected 0 0 0",
                     name, tail_data, tail_busy, framing_bad);
        end
    endtask

    task automatic test_reset();
        RSTB       = 1'b0;
        LOAD_VALID = 1'b0;
        LOAD_DATA  = '0;
        OUT_REQ    = 1'b0;
        #1;
        checks++;
        if ({OUT_ACK, OUT_DATA, BUSY, LOAD_READY} !== 4'b0001 || FIFO_LEVEL !== '0) begin
            errors++;
            $display("FAIL reset_values: ack/data/busy/ready=%b level=%0d expected 0001 level 0",
                     {OUT_ACK, OUT_DATA, BUSY, LOAD_READY}, FIFO_LEVEL);
        end
        tick();
        tick();
        @(negedge CLK);
        RSTB = 1'b1;
        tick();
    endtask

    task automatic test_hold_req();
        bit         seen;
        logic [7:0] w;
        logic       td, tb, fb;
        int         extra;
        push_word(8'hA5);
        push_word(8'($urandom));
        OUT_REQ = 1'b1;
        wait_ack(10, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL hold_ack: got no ACK expected ACK");
        end else begin
            collect_word(w, td, tb, fb);
            check_word("hold_a5", w, td, tb, fb);
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            if (OUT_ACK === 1'b1) extra++;
            tick();
        end
        checks++;
        if (extra != 0 || FIFO_LEVEL !== LW'(model_q.size())) begin
            errors++;
            $display("FAIL hold_single_word: got acks=%0d level=%0d expected 0 and %0d",
                     extra, FIFO_LEVEL, model_q.size());
        end
        OUT_REQ = 1'b0;
        tick();
        OUT_REQ = 1'b1;
        wait_ack(10, seen);
        OUT_REQ = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rearm_ack: got no ACK expected ACK");
        end else begin
            collect_word(w, td, tb, fb);
            check_word("rearm", w, td, tb, fb);
        end
        tick();
    endtask

    task automatic test_two_words();
        bit         seen;
        logic [7:0] w;
        logic       td, tb, fb;
        push_word(8'h3C);
        push_word(8'h81);
        checks++;
        if (FIFO_LEVEL !== LW'(2)) begin
            errors++;
            $display("FAIL level_two: got %0d expected 2", FIFO_LEVEL);
        end
        for (int k = 0; k < 2; k++) begin
            OUT_REQ = 1'b1;
            wait_ack(10, seen);
            OUT_REQ = 1'b0;
            checks++;
            if (!seen || FIFO_LEVEL !== LW'(model_q.size() - 1)) begin
                errors++;
                $display("FAIL pulse_ack_level: seen=%0d level=%0d expected 1 and %0d",
                         seen, FIFO_LEVEL, model_q.size() - 1);
            end
            if (seen) begin
                collect_word(w, td, tb, fb);
                check_word("pulse", w, td, tb, fb);
            end
            tick();
        end
    endtask

    task automatic test_overflow();
        bit         seen;
        logic       was_ready;
        logic [7:0] w;
        logic       td, tb, fb;
        OUT_REQ    = 1'b0;
        LOAD_VALID = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            LOAD_DATA = 8'($urandom);
            was_ready = LOAD_READY;
            checks++;
            if (was_ready !== (model_q.size() < DEPTH)) begin
                errors++;
                $display("FAIL ready_word%0d: got %b expected %b", i, was_ready,
                         model_q.size() < DEPTH);
            end
            w = LOAD_DATA;
            tick();
            if (was_ready) model_q.push_back(w);
        end
        LOAD_VALID = 1'b0;
        checks++;
        if (FIFO_LEVEL !== LW'(DEPTH) || LOAD_READY !== 1'b0) begin
            errors++;
            $display("FAIL full_state: level=%0d ready=%b expected %0d and 0",
                     FIFO_LEVEL, LOAD_READY, DEPTH);
        end
`ifdef BIT_SERIAL_TX_STATUS_EN
        checks++;
        if (OVF !== 1'b1) begin
            errors++;
            $display("FAIL ovf: got %b expected 1", OVF);
        end
`endif
        for (int k = 0; k < DEPTH; k++) begin
            OUT_REQ = 1'b1;
            wait_ack(10, seen);
            OUT_REQ = 1'b0;
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL drain_ack%0d: got no ACK expected ACK", k);
            end else begin
                collect_word(w, td, tb, fb);
                check_word("drain", w, td, tb, fb);
            end
            tick();
        end
    endtask

    task automatic test_empty_then_load();
        bit         seen;
        logic [7:0] w;
        logic       td, tb, fb;
        logic [2:0] acks;
        OUT_REQ = 1'b1;
        tick();
        tick();
        push_word(8'h7F);
        acks[0] = OUT_ACK;
        tick();
        acks[1] = OUT_ACK;
        tick();
        acks[2] = OUT_ACK;
        checks++;
        if (acks !== 3'b100) begin
            errors++;
            $display("FAIL load_latency: got ack E+2..E=%b expected 100", acks);
        end
        seen = (OUT_ACK === 1'b1);
        OUT_REQ = 1'b0;
        if (seen) begin
            collect_word(w, td, tb, fb);
            check_word("late_load", w, td, tb, fb);
        end else begin
            wait_ack(12, seen);
            if (seen) begin
                collect_word(w, td, tb, fb);
                void'(model_q.pop_front());
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit         seen;
        int         extra;
        push_word(8'h10 | 8'($urandom));
        push_word(8'($urandom));
        OUT_REQ = 1'b1;
        wait_ack(10, seen);
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (!seen || OUT_DATA !== 1'b1) begin
            errors++;
            $display("FAIL bit4_before_reset: seen=%0d data=%b expected 1 1", seen, OUT_DATA);
        end
        #2;
        RSTB = 1'b0;
        #1;
        model_q.delete();
        checks++;
        if ({OUT_ACK, OUT_DATA, BUSY, LOAD_READY} !== 4'b0001 || FIFO_LEVEL !== '0) begin
            errors++;
            $display("FAIL async_reset: ack/data/busy/ready=%b level=%0d expected 0001 level 0",
                     {OUT_ACK, OUT_DATA, BUSY, LOAD_READY}, FIFO_LEVEL);
        end
`ifdef BIT_SERIAL_TX_STATUS_EN
        acks_sent = 0;
        checks++;
        if (TX_COUNT !== 16'd0 || OVF !== 1'b0) begin
            errors++;
            $display("FAIL status_reset: count=%0d ovf=%b expected 0 0", TX_COUNT, OVF);
        end
`endif
        @(negedge CLK);
        RSTB = 1'b1;
        tick();
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            if (OUT_ACK === 1'b1) extra++;
            tick();
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL no_ack_after_reset: got %0d ACKs expected 0", extra);
        end
        OUT_REQ = 1'b0;
        tick();
    endtask

    task automatic test_random_stream();
        bit         seen;
        int         n;
        logic [7:0] w;
        logic       td, tb, fb;
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) push_word(8'($urandom));
            while (model_q.size() > 0) begin
                OUT_REQ = 1'b1;
                wait_ack(12, seen);
                OUT_REQ = 1'b0;
                checks++;
                if (!seen || FIFO_LEVEL !== LW'(model_q.size() - 1)) begin
                    errors++;
                    $display("FAIL rand_ack_level: seen=%0d level=%0d expected 1 and %0d",
                             seen, FIFO_LEVEL, model_q.size() - 1);
                end
                if (!seen) break;
                collect_word(w, td, tb, fb);
                check_word("random", w, td, tb, fb);
                for (int g = 0; g < $urandom_range(0, 3); g++) tick();
            end
            model_q.delete();
            tick();
        end
`ifdef BIT_SERIAL_TX_STATUS_EN
        checks++;
        if (TX_COUNT !== 16'(acks_sent)) begin
            errors++;
            $display("FAIL tx_count: got %0d expected %0d", TX_COUNT, acks_sent);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_hold_req();
        test_two_words();
        test_overflow();
        test_empty_then_load();
        test_reset_mid();
        test_random_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
